// File: rtl/ahb_dphase_sel.sv
// AHB-Lite data-phase select and response mux with a built-in default (error) slave.
// Optional wait-state watchdog is compiled in with `define AHB_DPSEL_TIMEOUT_EN.
module ahb_dphase_sel #(
    parameter int NSLAVE  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NSLAVE-1:0]         HSEL_DEC,
    input  logic [1:0]                HTRANS,
    input  logic [NSLAVE-1:0]         HREADYOUT_S,
    input  logic [NSLAVE-1:0]         HRESP_S,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [$clog2(NSLAVE)-1:0] MUX_SEL,
    output logic [NSLAVE-1:0]         MUX_SEL_OH,
    output logic                      DEF_ACTIVE
);

    localparam int SELW = $clog2(NSLAVE);

    if (NSLAVE < 2 || NSLAVE > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
        $fatal(1, "ahb_dphase_sel: NSLAVE or TIMEOUT outside legal range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    logic            slave_ready;
    logic            slave_resp;
    logic            accept;
    logic            sel_valid;
    logic [SELW-1:0] sel_idx;
    logic            unused_htrans0;

`ifdef AHB_DPSEL_TIMEOUT_EN
    logic [7:0]      wd_cnt;
`endif

    // BUSY and IDLE are treated alike, so only HTRANS[1] matters.
    assign unused_htrans0 = HTRANS[0];

    function automatic logic [SELW-1:0] oh_to_idx(input logic [NSLAVE-1:0] oh);
        logic [SELW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (oh[i]) idx = idx | SELW'(i);
        end
        return idx;
    endfunction

    // The one-hot register is zero outside DATA, so AND-OR picks the owner or nothing.
    assign slave_ready = |(HREADYOUT_S & MUX_SEL_OH);
    assign slave_resp  = |(HRESP_S & MUX_SEL_OH);

    assign sel_valid = (HSEL_DEC != '0) && ((HSEL_DEC & (HSEL_DEC - NSLAVE'(1))) == '0);
    assign sel_idx   = oh_to_idx(HSEL_DEC);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (state)
            ST_IDLE: begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
            ST_DATA: begin
                HREADY = slave_ready;
                HRESP  = slave_resp;
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ST_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
        endcase
    end

    assign accept = HREADY;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            MUX_SEL    <= '0;
            MUX_SEL_OH <= '0;
            DEF_ACTIVE <= 1'b0;
`ifdef AHB_DPSEL_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else if (accept) begin
            state      <= ST_IDLE;
            MUX_SEL    <= '0;
            MUX_SEL_OH <= '0;
            DEF_ACTIVE <= 1'b0;
`ifdef AHB_DPSEL_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
            if (HTRANS[1]) begin
                if (sel_valid) begin
                    state      <= ST_DATA;
                    MUX_SEL    <= sel_idx;
                    MUX_SEL_OH <= HSEL_DEC;
                end else begin
                    state      <= ST_ERR1;
                    DEF_ACTIVE <= 1'b1;
                end
            end
        end else begin
            case (state)
                ST_ERR1: state <= ST_ERR2;
`ifdef AHB_DPSEL_TIMEOUT_EN
                // Only stalled DATA cycles land here; abandon the slave once the limit is hit.
                ST_DATA: begin
                    if (wd_cnt == 8'(TIMEOUT)) begin
                        state      <= ST_ERR1;
                        MUX_SEL    <= '0;
                        MUX_SEL_OH <= '0;
                        DEF_ACTIVE <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dphase_sel.sv
// Self-checking bench for ahb_dphase_sel: directed scenarios plus randomized traffic
// compared against a transfer-level reference model.
module tb_ahb_dphase_sel;

    localparam int NS  = 4;
    localparam int TO  = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [NS-1:0] HSEL_DEC;
    logic [1:0]    HTRANS;
    logic [NS-1:0] HREADYOUT_S;
    logic [NS-1:0] HRESP_S;
    logic          HREADY;
    logic          HRESP;
    logic [1:0]    MUX_SEL;
    logic [NS-1:0] MUX_SEL_OH;
    logic          DEF_ACTIVE;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_dphase_sel #(.NSLAVE(NS), .TIMEOUT(TO)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL_DEC    (HSEL_DEC),
        .HTRANS      (HTRANS),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .MUX_SEL     (MUX_SEL),
        .MUX_SEL_OH  (MUX_SEL_OH),
        .DEF_ACTIVE  (DEF_ACTIVE)
    );

    always #5 HCLK = ~HCLK;

    // Observed outputs packed as {HREADY, HRESP, MUX_SEL, MUX_SEL_OH, DEF_ACTIVE}.
    logic [8:0] obs;
    assign obs = {HREADY, HRESP, MUX_SEL, MUX_SEL_OH, DEF_ACTIVE};

    function automatic logic [8:0] ev(input bit rdy, input bit rsp, input int sel,
                                      input logic [NS-1:0] oh, input bit def);
        return {rdy, rsp, 2'(sel), oh, def};
    endfunction

    function automatic string fmt(input logic [8:0] v);
        return $sformatf("rdy=%b rsp=%b sel=%0d oh=%b def=%b", v[8], v[7], v[6:5], v[4:1], v[0]);
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic idle_bus();
        HTRANS      = 2'b00;
        HSEL_DEC    = '0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        HRESET = 1'b1;
        idle_bus();
        repeat (2) tick();
        mid();
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        HRESET = 1'b0;
        mid();
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_release_idle: got %s want %s", fmt(obs), fmt(e)); end
        tick();
    endtask

    task automatic test_single_nonseq();
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = 4'b0100;
        mid();
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL single_addr_no_comb: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        idle_bus();
        mid();
        e = ev(1, 0, 2, 4'b0100, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL single_data_s2: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        mid();
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL single_back_idle: got %s want %s", fmt(obs), fmt(e)); end
        tick();
    endtask

    task automatic test_wait_hold();
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = 4'b0010;
        tick();
        HSEL_DEC    = 4'b1000;
        HREADYOUT_S = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            mid();
            e = ev(0, 0, 1, 4'b0010, 0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL wait_hold_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
            tick();
        end
        HREADYOUT_S = 4'b1111;
        mid();
        e = ev(1, 0, 1, 4'b0010, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wait_release: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        idle_bus();
        mid();
        e = ev(1, 0, 3, 4'b1000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wait_next_s3: got %s want %s", fmt(obs), fmt(e)); end
        tick();
    endtask

    task automatic test_decode_error(input logic [NS-1:0] hsel);
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = hsel;
        tick();
        idle_bus();
        mid();
        e = ev(0, 1, 0, 4'b0000, 1);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL decerr_%b_err1: got %s want %s", hsel, fmt(obs), fmt(e)); end
        tick();
        mid();
        e = ev(1, 1, 0, 4'b0000, 1);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL decerr_%b_err2: got %s want %s", hsel, fmt(obs), fmt(e)); end
        tick();
        mid();
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL decerr_%b_idle: got %s want %s", hsel, fmt(obs), fmt(e)); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = 4'b0000;
        tick();
        HSEL_DEC = 4'b0001;
        mid();
        e = ev(0, 1, 0, 4'b0000, 1);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_err1: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        mid();
        e = ev(1, 1, 0, 4'b0000, 1);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_err2: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        // Slaves 0,1,2,3 back to back, one zero-wait data cycle each.
        for (int s = 0; s < NS; s++) begin
            if (s < NS - 1) begin
                HTRANS   = 2'b11;
                HSEL_DEC = NS'(1) << (s + 1);
            end else begin
                idle_bus();
            end
            mid();
            e = ev(1, 0, s, NS'(1) << s, 0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL b2b_s%0d: got %s want %s", s, fmt(obs), fmt(e)); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = 4'b0100;
        tick();
        idle_bus();
        HREADYOUT_S = 4'b1011;
        mid();
        e = ev(0, 0, 2, 4'b0100, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL areset_wait: got %s want %s", fmt(obs), fmt(e)); end
        #1;
        HRESET = 1'b1;
        #1;
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL areset_no_edge: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        HRESET      = 1'b0;
        HREADYOUT_S = '1;
        tick();
    endtask

    task automatic test_watchdog();
        logic [8:0] e;
        HTRANS   = 2'b10;
        HSEL_DEC = 4'b0001;
        tick();
        idle_bus();
        HREADYOUT_S = 4'b1110;
`ifdef AHB_DPSEL_TIMEOUT_EN
        // Count reaches TO after TO stalled cycles; the slave is abandoned on the following edge.
        for (int i = 0; i <= TO; i++) begin
            mid();
            e = ev(0, 0, 0, 4'b0001, 0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL wd_wait_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
            tick();
        end
        mid();
        e = ev(0, 1, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wd_err1: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        mid();
        e = ev(1, 1, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wd_err2: got %s want %s", fmt(obs), fmt(e)); end
        tick();
        HREADYOUT_S = '1;
`else
        for (int i = 0; i < 10 * TO; i++) begin
            mid();
            e = ev(0, 0, 0, 4'b0001, 0);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL nowd_wait_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
            tick();
        end
        HREADYOUT_S = '1;
        mid();
        e = ev(1, 0, 0, 4'b0001, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL nowd_release: got %s want %s", fmt(obs), fmt(e)); end
        tick();
`endif
        mid();
        e = ev(1, 0, 0, 4'b0000, 0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL wd_back_idle: got %s want %s", fmt(obs), fmt(e)); end
        tick();
    endtask

    // Reference model tracks who owns the data phase: a slave index, the default
    // slave with N error cycles left, or nobody.
    task automatic test_random(input int cycles);
        int         owner    = -1;
        int         err_left = 0;
        bit         err_def  = 0;
        int         waits    = 0;
        bit         x_rdy;
        bit         x_rsp;
        logic [8:0] e;
        int         r;
        for (int c = 0; c < cycles; c++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       HSEL_DEC = NS'(1) << $urandom_range(0, NS - 1);
            else if (r == 7) HSEL_DEC = '0;
            else if (r == 8) HSEL_DEC = NS'($urandom);
            else             HSEL_DEC = '1;
            HTRANS = 2'($urandom_range(0, 3));
            for (int k = 0; k < NS; k++) begin
                HREADYOUT_S[k] = ($urandom_range(0, 9) < 7);
                HRESP_S[k]     = ($urandom_range(0, 9) < 2);
            end

            if (owner >= 0) begin
                x_rdy = HREADYOUT_S[owner];
                x_rsp = HRESP_S[owner];
                e = ev(x_rdy, x_rsp, owner, NS'(1) << owner, 0);
            end else if (err_left == 2) begin
                x_rdy = 0; x_rsp = 1;
                e = ev(0, 1, 0, '0, err_def);
            end else if (err_left == 1) begin
                x_rdy = 1; x_rsp = 1;
                e = ev(1, 1, 0, '0, err_def);
            end else begin
                x_rdy = 1; x_rsp = 0;
                e = ev(1, 0, 0, '0, 0);
            end

            mid();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %s want %s", c, fmt(obs), fmt(e));
            end

            if (x_rdy) begin
                owner = -1; err_left = 0; err_def = 0; waits = 0;
                if (HTRANS[1]) begin
                    if ($countones(HSEL_DEC) == 1) begin
                        for (int k = 0; k < NS; k++) if (HSEL_DEC[k]) owner = k;
                    end else begin
                        err_left = 2;
                        err_def  = 1;
                    end
                end
            end else if (err_left == 2) begin
                err_left = 1;
            end else if (owner >= 0) begin
`ifdef AHB_DPSEL_TIMEOUT_EN
                if (waits >= TO) begin
                    owner = -1; err_left = 2; err_def = 0;
                end else begin
                    waits++;
                end
`else
                waits++;
`endif
            end
            tick();
        end
        idle_bus();
        repeat (TO + 4) tick();
    endtask

    initial begin
        HRESET = 1'b1;
        idle_bus();
        test_reset();
        test_single_nonseq();
        test_wait_hold();
        test_decode_error(4'b0000);
        test_decode_error(4'b0110);
        test_back_to_back();
        test_async_reset();
        test_watchdog();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_dphase_sel.md
# ahb_dphase_sel

Parametrised AHB-Lite data-phase select and response mux for NSLAVE slaves, sitting between the address decoder and the read-data/response multiplexer. It registers the one-hot decoder select at the end of each accepted address phase and holds it through slave wait states. It drives the data-mux select and multiplexes the selected slave's HREADYOUT/HRESP back to the master. A built-in default slave answers unmapped or ambiguous transfers with a two-cycle ERROR response.

## Interface
- NSLAVE, 4, number of slaves; legal range 2..16.
- SELW, $clog2(NSLAVE), width of the encoded select; derived, not overridden.
- TIMEOUT, 16, wait-state limit for the watchdog; legal range 2..255. Used only when the watchdog is compiled in.
- HCLK  in  1  bus clock, single clock domain.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL_DEC  in  NSLAVE  one-hot address-phase select from the decoder.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HREADYOUT_S  in  NSLAVE  per-slave ready.
- HRESP_S  in  NSLAVE  per-slave response (1 = ERROR).
- HREADY  out  1  muxed ready to the master and to all slaves.
- HRESP  out  1  muxed response to the master.
- MUX_SEL  out  SELW  encoded data-phase slave index, for the HRDATA mux.
- MUX_SEL_OH  out  NSLAVE  one-hot data-phase select; all-zero when no slave owns the data phase.
- DEF_ACTIVE  out  1  high while the default slave owns the data phase.

## Operation
- Accept edge: any posedge HCLK with HREADY=1.
- Capture rules on an accept edge:
  - HTRANS[1]=1 with exactly one HSEL_DEC bit set: MUX_SEL_OH takes HSEL_DEC, MUX_SEL takes its index, state goes to DATA.
  - HTRANS[1]=1 with zero or more than one HSEL_DEC bit set: MUX_SEL_OH and MUX_SEL go to 0, state goes to ERR1.
  - HTRANS[1]=0 (IDLE/BUSY): MUX_SEL_OH and MUX_SEL go to 0, state goes to IDLE.
- No capture happens while HREADY=0. The select is held unchanged.
- States and outputs:
  - IDLE: HREADY=1, HRESP=0. This is the zero-wait OKAY response.
  - DATA: HREADY=HREADYOUT_S[MUX_SEL], HRESP=HRESP_S[MUX_SEL].
    - Slave two-cycle ERROR responses pass through transparently.
    - Leaving DATA follows the accept rules when HREADYOUT_S[MUX_SEL]=1.
  - ERR1: HREADY=0, HRESP=1. Always goes to ERR2 next.
  - ERR2: HREADY=1, HRESP=1. This is an accept edge, so a back-to-back transfer is captured.
- DEF_ACTIVE=1 in ERR1/ERR2 when entered by a decode error, and 0 otherwise.
- Reset:
  - State IDLE, MUX_SEL=0, MUX_SEL_OH=0, DEF_ACTIVE=0, watchdog count 0.
  - HREADY=1 and HRESP=0 follow combinationally.
  - Asserting HRESET mid-transfer or mid-ERROR aborts immediately, with no completion cycle.

## Timing
- Select latency: MUX_SEL and MUX_SEL_OH are registered. They are valid in the cycle after the accept edge, which is the first data-phase cycle.
- HREADY/HRESP are combinational from state and the slave inputs (Mealy in DATA). They carry no register delay from HREADYOUT_S.
- Minimum transfer: one data cycle for a zero-wait slave. Back-to-back NONSEQ/SEQ transfers to different slaves switch the select every cycle.
- Default-slave error: exactly 2 data-phase cycles, ERR1 then ERR2.
- No combinational path from HSEL_DEC or HTRANS to any output.

## Configuration
- AHB_DPSEL_TIMEOUT_EN defined: the wait-state watchdog is compiled in.
  - The counter is cleared on every accept edge into DATA.
  - It increments each DATA cycle with HREADYOUT_S[MUX_SEL]=0.
  - When the count reaches TIMEOUT, the block abandons the slave on the next edge and enters ERR1 with DEF_ACTIVE=0. The master sees ERR1/ERR2 as normal.
  - MUX_SEL_OH is cleared on entry to ERR1.
- AHB_DPSEL_TIMEOUT_EN undefined: no counter logic is present. DATA waits indefinitely on the slave, and TIMEOUT is ignored.

## Test plan
- Reset and idle:
  - HRESET=1, then release with HTRANS=00 → HREADY=1, HRESP=0, MUX_SEL=0, MUX_SEL_OH=0000, DEF_ACTIVE=0.
- Single NONSEQ to slave 2:
  - HSEL_DEC=0100, HTRANS=10, slave 2 zero-wait → next cycle MUX_SEL=2, MUX_SEL_OH=0100, HREADY=1.
- Wait-state hold:
  - Slave 1 drives HREADYOUT_S[1]=0 for 3 cycles while HSEL_DEC changes to 1000 → MUX_SEL stays 1 for all 3 cycles, and HREADY=0.
  - Slave 3 is selected only after HREADYOUT_S[1]=1.
- Decode error:
  - HSEL_DEC=0000 with HTRANS=10 → ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), DEF_ACTIVE=1 for both cycles.
  - Repeat with HSEL_DEC=0110 → same response.
- Back-to-back and async reset:
  - ERR2 followed immediately by NONSEQ to slave 0 → MUX_SEL=0, MUX_SEL_OH=0001 next cycle.
  - Assert HRESET during a DATA wait state → outputs reach reset values with no clock edge.
- Watchdog (macro defined, TIMEOUT=4):
  - Slave 0 holds HREADYOUT_S[0]=0 → after 4 wait cycles, ERR1 then ERR2 with DEF_ACTIVE=0.
  - Without the macro, the same stimulus gives HREADY=0 indefinitely.
